// File: rtl/pipe_test_seq_if.sv
// FIFO-side bundle for the test sequencer: F2P write port and P2F read port.
// The sequencer uses the master modport; the FIFOs (or a model) use slave.
interface pipe_test_seq_if #(
  parameter int unsigned DATA_W = 128
) ();
  logic              f2p_full;
  logic              f2p_wr_en;
  logic [DATA_W-1:0] f2p_din;
  logic              p2f_empty;
  logic              p2f_rd_en;
  logic [DATA_W-1:0] p2f_dout;
  logic              p2f_valid;

  modport master (
    input  f2p_full,
    output f2p_wr_en,
    output f2p_din,
    input  p2f_empty,
    output p2f_rd_en,
    input  p2f_dout,
    input  p2f_valid
  );

  modport slave (
    output f2p_full,
    input  f2p_wr_en,
    input  f2p_din,
    output p2f_empty,
    input  p2f_rd_en,
    output p2f_dout,
    output p2f_valid
  );
endinterface

// File: rtl/pipe_test_seq.sv
// Test traffic sequencer: writes a counting pattern into the F2P FIFO and checks
// that the same counting pattern comes back out of the P2F FIFO.
module pipe_test_seq #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tx_en,
  input  logic             rx_en,
  input  logic [CNT_W-1:0] word_count,
  pipe_test_seq_if.master  fifo,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [DATA_W-1:0] DataOne = DATA_W'(1);

  state_e            state_q, state_d;
  logic              start_acc;
  logic              tx_en_q, rx_en_q;
  logic [CNT_W-1:0]  wc_q;
  logic [CNT_W-1:0]  tx_count_q, rx_count_q, err_count_q, cycle_count_q, rd_issued_q;
  logic [DATA_W-1:0] din_q, exp_q;
  logic              run, tx_side_done, rx_side_done;
  logic              wr_en, rd_en, rx_take;

  assign run          = (state_q == StRun);
  assign tx_side_done = !tx_en_q || (tx_count_q == wc_q);
  assign rx_side_done = !rx_en_q || (rx_count_q == wc_q);

  assign wr_en   = run && tx_en_q && !fifo.f2p_full && (tx_count_q < wc_q);
  assign rd_en   = run && rx_en_q && !fifo.p2f_empty && (rd_issued_q < wc_q);
  // Reads are bounded by word_count, so a stray valid past that is never counted.
  assign rx_take = run && fifo.p2f_valid && (rx_count_q < wc_q);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          start_acc = 1'b1;
        end
      end
      StRun: begin
        if (tx_side_done && rx_side_done) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_en_q       <= 1'b0;
      rx_en_q       <= 1'b0;
      wc_q          <= '0;
      tx_count_q    <= '0;
      rx_count_q    <= '0;
      err_count_q   <= '0;
      cycle_count_q <= '0;
      rd_issued_q   <= '0;
      din_q         <= '0;
      exp_q         <= '0;
    end else if (start_acc) begin
      tx_en_q       <= tx_en;
      rx_en_q       <= rx_en;
      wc_q          <= word_count;
      tx_count_q    <= '0;
      rx_count_q    <= '0;
      err_count_q   <= '0;
      cycle_count_q <= '0;
      rd_issued_q   <= '0;
      din_q         <= '0;
      exp_q         <= '0;
    end else if (run) begin
      if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + CntOne;
      if (wr_en) begin
        tx_count_q <= tx_count_q + CntOne;
        din_q      <= din_q + DataOne;
      end
      if (rd_en) rd_issued_q <= rd_issued_q + CntOne;
      if (rx_take) begin
        rx_count_q <= rx_count_q + CntOne;
        // Expected value advances even on a bad word so one glitch costs one error.
        exp_q      <= exp_q + DataOne;
        if ((fifo.p2f_dout != exp_q) && (err_count_q != '1)) begin
          err_count_q <= err_count_q + CntOne;
        end
      end
    end
  end

  assign fifo.f2p_wr_en = wr_en;
  assign fifo.f2p_din   = din_q;
  assign fifo.p2f_rd_en = rd_en;
  assign busy           = run;
  assign done           = (state_q == StDone);
  assign tx_count       = tx_count_q;
  assign rx_count       = rx_count_q;
  assign err_count      = err_count_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_pipe_test_seq.sv
// Bench for pipe_test_seq: FIFO models on both ports, a table of directed runs,
// hand-written abort/priority sequences and randomized runs against a run-level model.
module tb_pipe_test_seq;
  localparam int unsigned DW   = 128;
  localparam int unsigned CW   = 32;
  localparam int          PatN = 200;
  localparam int          MemN = 64;

  typedef struct {
    bit tx;
    bit rx;
    int wc;
    int extra;
    int full_from;
    int full_len;
    int bad_idx;
    int restart_k;
    int exp_tx;
    int exp_rx;
    int exp_err;
    int exp_cyc;
  } vec_t;

  logic          sys_clk = 1'b0;
  logic          rst, start, tx_en, rx_en;
  logic [CW-1:0] word_count;
  logic          busy, done;
  logic [CW-1:0] tx_count, rx_count, err_count, cycle_count;

  pipe_test_seq_if #(.DATA_W(DW)) bus ();

  pipe_test_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start       (start),
    .tx_en       (tx_en),
    .rx_en       (rx_en),
    .word_count  (word_count),
    .fifo        (bus),
    .busy        (busy),
    .done        (done),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .err_count   (err_count),
    .cycle_count (cycle_count)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO models: P2F is a pre-filled array read in order, F2P writes are logged.
  logic          full_drv, stall_drv, fifo_clr;
  logic [DW-1:0] mem [MemN];
  logic [DW-1:0] wr_log [MemN];
  int            fill_n = 0;
  int            rd_ptr = 0;
  int            wr_n = 0;
  bit            full_pat [PatN];
  bit            stall_pat [PatN];

  assign bus.f2p_full  = full_drv;
  assign bus.p2f_empty = stall_drv || (rd_ptr >= fill_n);

  always @(posedge sys_clk) begin
    if (fifo_clr) begin
      rd_ptr        <= 0;
      wr_n          <= 0;
      bus.p2f_valid <= 1'b0;
      bus.p2f_dout  <= '0;
    end else begin
      bus.p2f_valid <= bus.p2f_rd_en;
      if (bus.p2f_rd_en) begin
        bus.p2f_dout <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1;
      end
      if (bus.f2p_wr_en) begin
        if (wr_n < MemN) wr_log[wr_n] <= bus.f2p_din;
        wr_n <= wr_n + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic prep_table(input vec_t v);
    for (int k = 0; k < PatN; k++) begin
      full_pat[k]  = (k >= v.full_from) && (k < v.full_from + v.full_len);
      stall_pat[k] = 1'b0;
    end
    for (int i = 0; i < MemN; i++) mem[i] = DW'(i);
    if (v.bad_idx >= 0) mem[v.bad_idx] = DW'(16'hDEAD);
  endtask

  task automatic do_run(input vec_t v, input string tag);
    int k;
    int viol;
    int seq_bad;
    fifo_clr = 1'b1;
    @(posedge sys_clk); #1;
    fifo_clr   = 1'b0;
    fill_n     = v.wc + v.extra;
    tx_en      = v.tx;
    rx_en      = v.rx;
    word_count = CW'(v.wc);
    start      = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    k     = 0;
    viol  = 0;
    while (done !== 1'b1 && k < PatN - 10) begin
      full_drv  = full_pat[k];
      stall_drv = stall_pat[k];
      if (k == v.restart_k) begin
        start      = 1'b1;
        word_count = CW'(1);
      end
      @(negedge sys_clk);
      if (bus.f2p_wr_en && bus.f2p_full) viol++;
      @(posedge sys_clk); #1;
      start      = 1'b0;
      word_count = CW'(v.wc);
      k++;
    end
    full_drv  = 1'b0;
    stall_drv = 1'b0;
    @(negedge sys_clk);
    check({tag, " run_len"}, k, v.exp_cyc);
    check({tag, " done"}, {busy, done}, 2'b01);
    check({tag, " done_strobes"}, {bus.f2p_wr_en, bus.p2f_rd_en}, 2'b00);
    check({tag, " tx_count"}, tx_count, v.exp_tx);
    check({tag, " rx_count"}, rx_count, v.exp_rx);
    check({tag, " err_count"}, err_count, v.exp_err);
    check({tag, " cycle_count"}, cycle_count, v.exp_cyc);
    check({tag, " f2p_din"}, bus.f2p_din, v.exp_tx);
    check({tag, " wr_pulses"}, wr_n, v.exp_tx);
    check({tag, " rd_pulses"}, rd_ptr, v.exp_rx);
    check({tag, " full_violation"}, viol, 0);
    seq_bad = 0;
    for (int i = 0; i < wr_n && i < MemN; i++) if (wr_log[i] !== DW'(i)) seq_bad++;
    check({tag, " wr_data_seq"}, seq_bad, 0);
  endtask

  vec_t tbl [10];

  initial begin
    vec_t v;
    int   nbad, cnt, t_tx, t_rx;

    rst        = 1'b1;
    start      = 1'b0;
    tx_en      = 1'b0;
    rx_en      = 1'b0;
    word_count = '0;
    full_drv   = 1'b0;
    stall_drv  = 1'b0;
    fifo_clr   = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset busy_done", {busy, done}, 2'b00);
    check("reset counters", {tx_count, rx_count, err_count, cycle_count}, '0);
    check("reset f2p_din", bus.f2p_din, '0);
    check("reset strobes", {bus.f2p_wr_en, bus.p2f_rd_en}, 2'b00);
    rst      = 1'b0;
    fifo_clr = 1'b0;

    // Abort a transmit run after three words; rst also wins over a concurrent start.
    for (int i = 0; i < MemN; i++) mem[i] = DW'(i);
    fill_n     = 0;
    tx_en      = 1'b1;
    rx_en      = 1'b0;
    word_count = CW'(8);
    start      = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge sys_clk); #1;
    end
    check("abort pre tx_count", tx_count, 3);
    check("abort pre wr_en", bus.f2p_wr_en, 1'b1);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    check("abort busy_done", {busy, done}, 2'b00);
    check("abort counters", {tx_count, rx_count, err_count, cycle_count}, '0);
    check("abort f2p_din", bus.f2p_din, '0);
    check("abort wr_en", bus.f2p_wr_en, 1'b0);
    @(posedge sys_clk); #1;
    check("rst_over_start busy", busy, 1'b0);
    rst   = 1'b0;
    start = 1'b0;

    //          tx rx wc ext ffrom flen bad  rst  etx erx err cyc
    tbl[0] = '{1, 1, 0,  0,  0,    0,   -1,  -1,  0,  0,  0,  1};
    tbl[1] = '{1, 0, 8,  0,  0,    0,   -1,  -1,  8,  0,  0,  9};
    tbl[2] = '{1, 0, 8,  0,  3,    4,   -1,  -1,  8,  0,  0,  13};
    tbl[3] = '{0, 1, 16, 0,  0,    0,   -1,  -1,  0,  16, 0,  18};
    tbl[4] = '{0, 1, 16, 0,  0,    0,   5,   -1,  0,  16, 1,  18};
    tbl[5] = '{1, 1, 16, 0,  0,    0,   -1,  -1,  16, 16, 0,  18};
    tbl[6] = '{0, 0, 5,  0,  0,    0,   -1,  -1,  0,  0,  0,  1};
    tbl[7] = '{0, 1, 10, 10, 0,    0,   -1,  -1,  0,  10, 0,  12};
    tbl[8] = '{1, 0, 8,  0,  0,    0,   -1,  2,   8,  0,  0,  9};
    tbl[9] = '{1, 1, 16, 0,  2,    3,   -1,  -1,  16, 16, 0,  20};
    for (int t = 0; t < 10; t++) begin
      prep_table(tbl[t]);
      do_run(tbl[t], $sformatf("vec%0d", t));
    end

    // Random runs; the model derives run length from when each side finishes.
    for (int r = 0; r < 25; r++) begin
      v.tx        = 1'($urandom_range(0, 1));
      v.rx        = 1'($urandom_range(0, 1));
      v.wc        = int'($urandom_range(0, 24));
      v.extra     = int'($urandom_range(0, 4));
      v.full_from = 0;
      v.full_len  = 0;
      v.bad_idx   = -1;
      v.restart_k = -1;
      for (int k = 0; k < PatN; k++) begin
        full_pat[k]  = ($urandom_range(0, 2) == 0);
        stall_pat[k] = ($urandom_range(0, 2) == 0);
      end
      nbad = 0;
      for (int i = 0; i < MemN; i++) begin
        mem[i] = DW'(i);
        if (i < v.wc + v.extra && $urandom_range(0, 7) == 0) begin
          mem[i] = ~DW'(i);
          if (i < v.wc) nbad++;
        end
      end
      t_tx = 0;
      if (v.tx && v.wc > 0) begin
        cnt = 0;
        for (int k = 0; k < PatN; k++) begin
          if (!full_pat[k]) cnt++;
          if (cnt == v.wc) begin
            t_tx = k + 1;
            break;
          end
        end
      end
      t_rx = 0;
      if (v.rx && v.wc > 0) begin
        cnt = 0;
        for (int k = 0; k < PatN; k++) begin
          if (!stall_pat[k]) cnt++;
          if (cnt == v.wc) begin
            t_rx = k + 2;
            break;
          end
        end
      end
      v.exp_tx  = v.tx ? v.wc : 0;
      v.exp_rx  = v.rx ? v.wc : 0;
      v.exp_err = v.rx ? nbad : 0;
      v.exp_cyc = ((t_tx > t_rx) ? t_tx : t_rx) + 1;
      do_run(v, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_test_seq.md
PIPE_TEST_SEQ -- requirements
Module: pipe_test_seq

Interface
REQ-001 Parameter DATA_W, default 128: width of F2P write data and P2F read data, in bits.
REQ-002 Parameter CNT_W, default 32: width of every count input and output.
REQ-003 sys_clk  in  1  single clock for all logic; both FIFO ports attached to this block run on it.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle run request.
REQ-006 tx_en  in  1  enables the generator (F2P) for the run; sampled on accepted start.
REQ-007 rx_en  in  1  enables the checker (P2F) for the run; sampled on accepted start.
REQ-008 word_count  in  CNT_W  words per enabled direction; sampled on accepted start.
REQ-009 f2p_full  in  1  F2P FIFO full flag.
REQ-010 f2p_wr_en  out  1  F2P FIFO write strobe.
REQ-011 f2p_din  out  DATA_W  F2P FIFO write data.
REQ-012 p2f_empty  in  1  P2F FIFO empty flag.
REQ-013 p2f_rd_en  out  1  P2F FIFO read strobe.
REQ-014 p2f_dout  in  DATA_W  P2F FIFO read data.
REQ-015 p2f_valid  in  1  P2F FIFO data valid; one cycle after an accepted read.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  high in DONE.
REQ-018 tx_count, rx_count, err_count, cycle_count  out  CNT_W each  run statistics.

Function
REQ-019 FSM states are IDLE, RUN and DONE.
REQ-020 IDLE->RUN on start; DONE->RUN on start; start in RUN is ignored.
REQ-021 On an accepted start:
- tx_en, rx_en and word_count are latched.
- All four counters and the expected-data register are cleared to 0.
- f2p_din is cleared to 0.
REQ-022 RUN->DONE in the cycle after both conditions hold:
- tx side complete: tx_count==word_count, or tx_en latched 0;
- rx side complete: rx_count==word_count, or rx_en latched 0.
REQ-023 With word_count==0, or with both enables 0, RUN lasts exactly 1 cycle.
REQ-024 f2p_wr_en = RUN & tx_en & !f2p_full & (tx_count<word_count); combinational; never high while f2p_full=1.
REQ-025 On each f2p_wr_en cycle:
- tx_count increments;
- f2p_din increments by 1, modulo 2^DATA_W.
- Write data sequence is therefore 0,1,2,...
REQ-026 p2f_rd_en = RUN & rx_en & !p2f_empty & (rd_issued<word_count); combinational.
- rd_issued is an internal count of reads issued.
- The block never reads more than word_count words.
REQ-027 On each p2f_valid cycle while in RUN:
- rx_count increments;
- p2f_dout is compared with the expected value;
- on mismatch, err_count increments, saturating at all-ones;
- the expected value increments by 1, whether or not the word matched.
- Expected sequence is 0,1,2,...
REQ-028 p2f_valid outside RUN is ignored.
REQ-029 cycle_count increments every RUN cycle, saturating, and holds in DONE and IDLE.
REQ-030 tx_count and rx_count never exceed the latched word_count.
REQ-031 Simultaneous f2p write and p2f valid in one cycle are both processed.
REQ-032 In DONE:
- strobes are 0;
- counters hold until the next accepted start or rst.

Reset
REQ-033 rst=1 at a clock edge forces IDLE and clears to 0:
- all outputs, including counters and f2p_din;
- latched configuration, rd_issued and expected value.
REQ-034 rst has priority over start in the same cycle.
REQ-035 rst in RUN aborts the run; strobes are 0 from the next cycle; no further words are counted.

Verification
REQ-036 tx_en=1, rx_en=0, word_count=8, f2p_full=0 -> 8 consecutive writes of data 0..7, tx_count=8, then done=1; cycle_count=9.
REQ-037 Same run with f2p_full held high for 4 cycles mid-run -> wr_en=0 in those cycles, data stays continuous 0..7, cycle_count=13.
REQ-038 Loopback (the P2F model returns 0..15), rx_en=1, word_count=16 -> rx_count=16, err_count=0.
REQ-039 Loopback, word 5 corrupted to 0xDEAD -> err_count=1 and rx_count=16; word 6 is still checked against 6 and passes.
REQ-040 P2F FIFO pre-filled with 20 words, word_count=10 -> exactly 10 rd_en pulses; 10 words remain in the FIFO.
REQ-041 rst asserted at tx_count=3 -> next cycle: IDLE, all counters 0, f2p_wr_en=0.
- A following start with word_count=0 -> done=1 after 1 RUN cycle.
- start asserted while busy has no effect.
